hdc_ngram_encoder: RTL and testbench
====================================

Name: hdc_ngram_encoder

Overview:
- Parametrised hyperdimensional n-gram encoder with a shared item memory and LANES independent encode lanes.
- Item memory is filled with random hypervectors through a write port.
- Each lane streams item addresses; each fetched hypervector is rotated right by its position in the n-gram.
- Rotated vectors are combined by XOR binding (mode 0) or bitwise-majority bundling (mode 1). The lane result is emitted through a valid/ready output.
- Sits between the host stream DMA and the classifier.

Parameters:
DW, 32, hypervector width in bits (power of 2, >=8)
DEPTH, 1024, item memory entries (power of 2)
AW, $clog2(DEPTH), item address width
LANES, 2, parallel encode lanes sharing one input handshake
CNTW, 8, bundle per-bit counter and element-count width

Ports:
clk  in  1  sole clock
rst  in  1  synchronous active-high reset
gen_we  in  1  item memory write strobe
gen_addr  in  AW  item memory write address
gen_data  in  DW  random hypervector to store
mode  in  1  0 = bind (XOR), 1 = bundle (majority); sampled on the first element of each n-gram
in_valid  in  1  element valid
in_ready  out  1  element accepted when in_valid && in_ready
in_addr  in  LANES*AW  per-lane item address, lane k at bits [k*AW +: AW]
in_last  in  1  element closes the n-gram (all lanes)
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  LANES*DW  per-lane result, lane k at bits [k*DW +: DW]
busy  out  1  n-gram in progress or pipeline occupied

Behaviour:
- Reset: rst=1 at a clk edge clears the pipeline, the rotation counter, accumulators, bundle counters, element count and the latched mode.
  - Outputs after reset: out_valid=0, out_data=0, busy=0. in_ready is 0 while rst=1.
  - Item memory contents are NOT cleared.
  - Reset mid-n-gram discards the partial n-gram.
- Item memory: single block RAM, 1 write port and LANES read ports, 1-cycle read latency. gen_we writes mem[gen_addr] <= gen_data.
- in_ready = !rst && !gen_we && !(out_valid && !out_ready) && !(s1_valid && s1_last).
  - Consequence: at most one closing element is in flight at a time. A length-1 n-gram therefore has 1/2 throughput.
- Pipeline:
  - Cycle t (accept edge): read addresses are registered, and the element is tagged with rot = perm_cnt, first flag and last flag.
  - Cycle t+1 (stage s1): each lane rotates its read data right by rot: (hv >> rot) | (hv << (DW - rot)), with rot=0 leaving the vector unchanged. The rotated vector is then combined.
  - Results register at the t+1 edge. out_valid becomes visible in cycle t+2 after the edge accepting the last element.
- perm_cnt: width $clog2(DW).
  - Increments per accepted element, wrapping DW-1 -> 0.
  - Resets to 0 after an element with in_last is accepted.
- Mode latch: mode is captured on the first element of an n-gram (perm_cnt==0 and no n-gram open) and held until in_last. Changes to mode mid-n-gram are ignored.
- Bind mode, per lane:
  - First element: acc <= rotated.
  - Other elements: acc <= acc ^ rotated.
- Bundle mode, per lane:
  - First element: ctr[b] <= rotated[b] and n <= 1.
  - Other elements: ctr[b] += rotated[b] and n += 1. Both saturate at 2^CNTW-1.
  - At last: result bit b = (2*ctr[b] > n). A tie gives 0.
- On an s1 element with the last flag: out_data <= final result of every lane, out_valid <= 1, and the accumulator state is treated as empty.
  - The next element accepted is a first element, even if it was accepted in the same cycle the last element sits in s1.
- Output register holds out_data and out_valid stable until out_valid && out_ready. out_valid falls the next cycle unless new data is written in the same cycle.
- busy = s1_valid || n-gram open || out_valid.
- gen_we while in_valid=1: the write takes priority, in_ready=0 and nothing is accepted. Write-during-read hazards cannot occur because reads are only issued when gen_we=0.

Test Plan:
- Bind chain: mem[0]=0x00000001, mem[1]=0x80000000, mem[2]=0x0000000F; lane0 addresses 0,1,2 with last on 2, mode=0 -> lane0 out=0x80000002, out_valid 2 cycles after the last is accepted.
- Bundle majority: mem[3]=0xFFFFFFFF, mem[4]=0x55555555; lane1 addresses 3,4,3, mode=1 -> 0xFFFFFFFF. Addresses 3,4 only (tie case) -> 0xAAAAAAAA shows as bits with count 2/2 = 1 and bits with count 1/2 tie = 0, giving lane1 out=0xAAAAAAAA.
- Rotation wrap: mem[0]=1, 33 elements of address 0 with last on the 33rd, mode=0 -> 0xFFFFFFFE; perm_cnt returns to 0.
- Backpressure: out_ready=0, two length-1 n-grams (addresses 0 then 1) -> first held stable and in_ready=0 until release. Then out_ready=1 -> results 0x00000001 then 0x80000000 in order, with none lost or duplicated.
- Reset mid-n-gram: accept addresses 1,2, pulse rst for 1 cycle, then a single-element n-gram of address 0 -> out=0x00000001, memory intact, out_valid=0 and busy=0 during reset.
- Write priority: gen_we=1 with in_valid=1 -> in_ready=0 and no element consumed. Lanes 0 and 1 with different addresses in the same element produce independent results.

Source files
------------

// File: rtl/hdc_ngram_encoder.sv
// Hyperdimensional n-gram encoder: shared item memory, LANES encode lanes,
// per-element right rotation and XOR-bind or majority-bundle combination.
module hdc_ngram_encoder #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int LANES = 2,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gen_we,
  input  logic [AW-1:0]         gen_addr,
  input  logic [DW-1:0]         gen_data,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*AW-1:0]   in_addr,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic                  busy
);
  localparam int RW = $clog2(DW);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_data_r [LANES];

  logic            s1_valid_r;
  logic            s1_first_r;
  logic            s1_last_r;
  logic [RW-1:0]   s1_rot_r;
  logic [RW-1:0]   perm_cnt_r;
  logic            open_r;
  logic            mode_r;

  logic [DW-1:0]   acc_r [LANES];
  logic [CNTW-1:0] ctr_r [LANES][DW];
  logic [CNTW-1:0] n_r;

  logic                out_valid_r;
  logic [LANES*DW-1:0] out_data_r;

  logic                accept_s;
  logic [DW-1:0]       rot_s [LANES];
  logic [DW-1:0]       acc_nx_s [LANES];
  logic [DW-1:0]       maj_s [LANES];
  logic [CNTW-1:0]     ctr_nx_s [LANES][DW];
  logic [CNTW-1:0]     n_nx_s;
  logic [LANES*DW-1:0] result_s;

  // Rotate right by rot: shifting the doubled vector wraps the low bits around.
  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] hv, input logic [RW-1:0] rot);
    logic [2*DW-1:0] dbl;
    dbl = {hv, hv} >> rot;
    return dbl[DW-1:0];
  endfunction

  // Only one closing element may be in flight, so a pending last blocks input.
  assign in_ready  = !rst && !gen_we && !(out_valid_r && !out_ready) && !(s1_valid_r && s1_last_r);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = s1_valid_r || open_r || out_valid_r;

  // Item memory write port and per-lane synchronous read ports.
  always_ff @(posedge clk) begin
    if (gen_we) begin
      mem[gen_addr] <= gen_data;
    end
    for (int k = 0; k < LANES; k++) begin
      if (accept_s) begin
        rd_data_r[k] <= mem[in_addr[k*AW +: AW]];
      end
    end
  end

  // Accept stage: rotation counter, open n-gram tracking, mode latch, s1 tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      perm_cnt_r <= {RW{1'b0}};
      open_r     <= 1'b0;
      mode_r     <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_rot_r   <= {RW{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_rot_r   <= perm_cnt_r;
        s1_first_r <= !open_r;
        s1_last_r  <= in_last;
        if (!open_r) begin
          mode_r <= mode;
        end
        if (in_last) begin
          perm_cnt_r <= {RW{1'b0}};
          open_r     <= 1'b0;
        end else begin
          perm_cnt_r <= perm_cnt_r + RW'(1'b1);
          open_r     <= 1'b1;
        end
      end
    end
  end

  // Stage s1: rotate, then compute next bind accumulator, bundle counters and result.
  always_comb begin
    result_s = {(LANES*DW){1'b0}};
    if (s1_first_r) begin
      n_nx_s = CNTW'(1'b1);
    end else if (n_r == CNT_MAX) begin
      n_nx_s = n_r;
    end else begin
      n_nx_s = n_r + CNTW'(1'b1);
    end
    for (int k = 0; k < LANES; k++) begin
      rot_s[k]    = rotr(rd_data_r[k], s1_rot_r);
      acc_nx_s[k] = s1_first_r ? rot_s[k] : (acc_r[k] ^ rot_s[k]);
      maj_s[k]    = {DW{1'b0}};
      for (int b = 0; b < DW; b++) begin
        if (s1_first_r) begin
          ctr_nx_s[k][b] = {{(CNTW-1){1'b0}}, rot_s[k][b]};
        end else if (ctr_r[k][b] == CNT_MAX) begin
          ctr_nx_s[k][b] = ctr_r[k][b];
        end else begin
          ctr_nx_s[k][b] = ctr_r[k][b] + {{(CNTW-1){1'b0}}, rot_s[k][b]};
        end
        // Strict majority: a tie resolves to 0.
        maj_s[k][b] = ({ctr_nx_s[k][b], 1'b0} > {1'b0, n_nx_s});
      end
      result_s[k*DW +: DW] = mode_r ? maj_s[k] : acc_nx_s[k];
    end
  end

  // Accumulator and bundle counter state, advanced by every s1 element.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r <= {CNTW{1'b0}};
      for (int k = 0; k < LANES; k++) begin
        acc_r[k] <= {DW{1'b0}};
        for (int b = 0; b < DW; b++) begin
          ctr_r[k][b] <= {CNTW{1'b0}};
        end
      end
    end else if (s1_valid_r) begin
      n_r <= n_nx_s;
      for (int k = 0; k < LANES; k++) begin
        acc_r[k] <= acc_nx_s[k];
        for (int b = 0; b < DW; b++) begin
          ctr_r[k][b] <= ctr_nx_s[k][b];
        end
      end
    end
  end

  // Output register: loaded by a closing element, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(LANES*DW){1'b0}};
    end else if (s1_valid_r && s1_last_r) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdc_ngram_encoder.sv
// Self-checking bench for hdc_ngram_encoder: directed scenarios plus random
// n-grams scored against a behavioural model of the encoding rules.
module tb_hdc_ngram_encoder;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, gen_we, mode, in_valid, in_last, out_ready;
  logic [AW-1:0] gen_addr;
  logic [DW-1:0] gen_data;
  logic [2*AW-1:0] in_addr;
  logic          in_ready, out_valid, busy;
  logic [2*DW-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [16];
  int          seq_a [2][48];
  logic [63:0] exp_q [$];
  bit          rdy_rand = 1'b0;
  bit          hold_pend = 1'b0;

  hdc_ngram_encoder #(.DW(DW), .DEPTH(1024), .AW(AW), .LANES(2), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .gen_we(gen_we), .gen_addr(gen_addr), .gen_data(gen_data),
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: element i is rotated right by i mod DW, then XOR-bound or bundled by majority.
  function automatic logic [31:0] model_lane(input logic md, input int len, input int lane);
    logic [31:0] acc, hv, r;
    int cnt [32];
    int n;
    acc = 32'h0;
    n = 0;
    for (int b = 0; b < 32; b++) cnt[b] = 0;
    for (int i = 0; i < len; i++) begin
      hv = m_mem[seq_a[lane][i]];
      for (int j = 0; j < 32; j++) r[j] = hv[(j + i) % 32];
      acc = acc ^ r;
      if (n < 255) n++;
      for (int b = 0; b < 32; b++) if (r[b] && cnt[b] < 255) cnt[b]++;
    end
    if (md) for (int b = 0; b < 32; b++) acc[b] = (2 * cnt[b] > n);
    return acc;
  endfunction

  task automatic mem_write(input int a, input logic [31:0] d);
    gen_we = 1'b1; gen_addr = AW'(a); gen_data = d; m_mem[a] = d;
    @(posedge clk); #1;
    gen_we = 1'b0;
  endtask

  task automatic send_elem(input int a0, input int a1, input logic last, input logic md);
    bit ok = 1'b0;
    in_valid = 1'b1; in_addr = {AW'(a1), AW'(a0)}; in_last = last; mode = md;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("in_ready_timeout", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; mode = 1'($urandom_range(0, 1));
  endtask

  // Mode is driven randomly after the first element to show it is ignored mid-n-gram.
  task automatic run_ngram(input logic md, input int len);
    logic [63:0] e;
    e[31:0]  = model_lane(md, len, 0);
    e[63:32] = model_lane(md, len, 1);
    exp_q.push_back(e);
    for (int i = 0; i < len; i++)
      send_elem(seq_a[0][i], seq_a[1][i], (i == len - 1), (i == 0) ? md : 1'($urandom_range(0, 1)));
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) begin
      seq_a[0][i] = $urandom_range(0, 15);
      seq_a[1][i] = $urandom_range(0, 15);
    end
  endtask

  task automatic wait_out(input string tag, input int lane, input logic [31:0] expv);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check_val({tag, "_seen"}, {63'h0, seen}, 64'h1);
    if (seen) check_val(tag, {32'h0, (lane == 1) ? out_data[63:32] : out_data[31:0]}, {32'h0, expv});
    @(posedge clk); #1;
  endtask

  // Scoreboard: every valid cycle must show the oldest expected result.
  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      if (hold_pend) check_val("hold_valid", {63'h0, out_valid}, 64'h1);
      hold_pend = 1'b0;
      if (out_valid === 1'b1) begin
        check_val("sb_nonempty", {63'h0, exp_q.size() > 0}, 64'h1);
        if (exp_q.size() > 0) begin
          check_val("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
          else hold_pend = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    rst = 1'b1; gen_we = 1'b0; gen_addr = '0; gen_data = '0; mode = 1'b0;
    in_valid = 1'b1; in_addr = '0; in_last = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check_val("rst_out_data", out_data, 64'h0);
    check_val("rst_busy", {63'h0, busy}, 64'h0);
    check_val("rst_in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;

    mem_write(0, 32'h00000001);
    mem_write(1, 32'h80000000);
    mem_write(2, 32'h0000000F);
    mem_write(3, 32'hFFFFFFFF);
    mem_write(4, 32'h55555555);
    for (int a = 6; a < 16; a++) mem_write(a, $urandom);

    // Write priority: a pending element must not be taken while gen_we is high.
    in_valid = 1'b1; in_addr = {AW'(2), AW'(1)}; in_last = 1'b1;
    gen_we = 1'b1; gen_addr = AW'(5); gen_data = $urandom; m_mem[5] = gen_data;
    @(negedge clk);
    check_val("wp_in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk); #1;
    gen_we = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check_val("wp_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;

    // Bind chain with latency check.
    seq_a[0][0] = 0; seq_a[0][1] = 1; seq_a[0][2] = 2;
    seq_a[1][0] = 3; seq_a[1][1] = 7; seq_a[1][2] = 9;
    run_ngram(1'b0, 3);
    @(negedge clk);
    check_val("lat_t1", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    check_val("lat_t2", {63'h0, out_valid}, 64'h1);
    check_val("bind_chain", {32'h0, out_data[31:0]}, 64'h80000002);
    @(posedge clk); #1;

    // Bundle majority and tie.
    fill_rand(3);
    seq_a[1][0] = 3; seq_a[1][1] = 4; seq_a[1][2] = 3;
    run_ngram(1'b1, 3);
    wait_out("bundle_maj", 1, 32'hFFFFFFFF);
    fill_rand(2);
    seq_a[1][0] = 3; seq_a[1][1] = 4;
    run_ngram(1'b1, 2);
    wait_out("bundle_tie", 1, 32'hAAAAAAAA);

    // Rotation wrap over 33 elements.
    fill_rand(33);
    for (int i = 0; i < 33; i++) seq_a[0][i] = 0;
    run_ngram(1'b0, 33);
    wait_out("rot_wrap", 0, 32'hFFFFFFFE);
    fill_rand(1);
    seq_a[0][0] = 2;
    run_ngram(1'b0, 1);
    wait_out("perm_restart", 0, 32'h0000000F);

    // Backpressure: two length-1 n-grams behind a stalled output.
    out_ready = 1'b0;
    fork
      begin
        fill_rand(1); seq_a[0][0] = 0; run_ngram(1'b0, 1);
        fill_rand(1); seq_a[0][0] = 1; run_ngram(1'b0, 1);
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check_val("bp_in_ready", {63'h0, in_ready}, 64'h0);
          check_val("bp_hold", {32'h0, out_data[31:0]}, 64'h1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_out("bp_second", 0, 32'h80000000);

    // Reset mid-n-gram discards the partial state but keeps memory.
    send_elem(1, 1, 1'b0, 1'b1);
    send_elem(2, 2, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_pulse_in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_pulse_out_valid", {63'h0, out_valid}, 64'h0);
    check_val("rst_pulse_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    fill_rand(1); seq_a[0][0] = 0;
    run_ngram(1'b0, 1);
    wait_out("post_rst", 0, 32'h00000001);

    // Random n-grams with random output backpressure.
    rdy_rand = 1'b1;
    for (int t = 0; t < 30; t++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 5);
      fill_rand(len);
      run_ngram(1'($urandom_range(0, 1)), len);
    end
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_val("sb_drain", 64'(exp_q.size()), 64'h0);
    repeat (2) @(negedge clk);
    check_val("final_busy", {63'h0, busy}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
